mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB in the XYZ core.
- Performs data loads and stores over a Wishbone B4 classic master port. Handles byte/half/word alignment and sign/zero extension, and detects misaligned and bus-error traps.
- Registers all results into the MEM/WB pipeline register that feeds the writeback stage.
- Stalls the pipeline while a bus cycle is outstanding.

Parameters:
- TRAP_LD_MISALIGN, 4'd4, trap code for a misaligned load.
- TRAP_LD_FAULT, 4'd5, trap code for a load bus error.
- TRAP_ST_MISALIGN, 4'd6, trap code for a misaligned store.
- TRAP_ST_FAULT, 4'd7, trap code for a store bus error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- valid_i  in  1  the EX/MEM slot holds an instruction.
- pc_mem_i  in  32  instruction PC.
- pc4_mem_i  in  32  PC+4.
- alu_result_i  in  32  ALU result / effective address.
- store_data_i  in  32  rs2 value for stores.
- rd_mem_i  in  5  destination register.
- is_load_i, is_store_i  in  1 each  memory operation type.
- mem_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word).
- mem_unsigned_i  in  1  zero-extend the load result.
- rf_we_i  in  1  register-file write enable.
- mux_sel_i  in  2  WB mux select, passed through.
- csr_op_i  in  2  passed through.
- is_csr_i, is_rs1_i  in  1 each  passed through.
- csr_data_i  in  32  passed through.
- csr_addr_i  in  12  passed through.
- is_trap_i  in  1  trap raised upstream.
- trap_code_i  in  4  upstream trap code.
- flush_i  in  1  kill the current instruction (from the hazard unit).
- dwbm_adr_o  out  32  word-aligned bus address.
- dwbm_dat_o  out  32  store data.
- dwbm_sel_o  out  4  byte lane selects.
- dwbm_we_o  out  1  write enable.
- dwbm_cyc_o, dwbm_stb_o  out  1 each  bus cycle / strobe.
- dwbm_dat_i  in  32  read data.
- dwbm_ack_i, dwbm_err_i  in  1 each  bus termination.
- mem_stall_o  out  1  hold EX/MEM and all upstream stages.
- valid_wb_o  out  1  registered MEM/WB valid.
- pc_wb_o, pc4_wb_o  out  32 each  registered PC and PC+4.
- rd_wb_o  out  5  registered destination register.
- data_or_alu_o  out  32  registered load data or ALU result.
- rf_we_wb_o  out  1  registered write enable.
- mux_sel_wb_o, csr_op_wb_o  out  2 each  registered pass-through.
- is_csr_wb_o, is_rs1_wb_o  out  1 each  registered pass-through.
- csr_data_wb_o  out  32  registered pass-through.
- csr_addr_wb_o  out  12  registered pass-through.
- is_trap_wb_o  out  1  registered trap flag.
- trap_code_wb_o  out  4  registered trap code.

Behaviour:
- Reset: state=IDLE; every registered output =0, including the cyc/stb/we/sel/adr/dat bus outputs. mem_stall_o=0.
- Reset during BUS: cyc/stb drop at that edge and a late ack is ignored.
- mem_req = valid_i & (is_load_i|is_store_i) & !is_trap_i & !misaligned & !flush_i.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- FSM IDLE:
  - If mem_req, register the bus outputs and go to BUS. mem_stall_o=1 this cycle and the WB register loads a bubble.
  - Otherwise, pass through in 1 cycle.
- FSM BUS: cyc=stb=1 held stable.
  - mem_stall_o = !(dwbm_ack_i|dwbm_err_i).
  - On ack or err: the WB register captures the result, cyc/stb drop at that edge, return to IDLE.
  - Ack is accepted in the first BUS cycle at earliest, so a memory op takes ≥2 cycles.
  - ack and err together: err wins.
- Bubble means valid_wb_o=0, rf_we_wb_o=0, is_trap_wb_o=0, is_csr_wb_o=0; other fields don't-care.
- Store lanes:
  - byte: sel=0001<<a[1:0], data = byte replicated ×4.
  - half: sel=0011<<a[1:0], data = half replicated ×2.
  - word: sel=1111.
  - adr = {addr[31:2],2'b00}.
- Load extract: select the lane by a[1:0]. Sign-extend unless mem_unsigned_i. Word is unchanged.
- Non-memory ops: data_or_alu_o=alu_result_i.
- Misaligned access: no bus cycle.
  - is_trap_wb_o=1, trap_code=TRAP_LD/ST_MISALIGN.
  - rf_we_wb_o=0.
  - csr_data_wb_o = effective address (mtval).
- Bus err: same as misaligned but with the *_FAULT code.
- Upstream is_trap_i: suppresses any access; trap and code pass through unchanged with rf_we_wb_o=0.
- flush_i in IDLE: the next WB is a bubble and no bus cycle starts.
- flush_i in BUS: the transaction runs to ack/err, then the result is discarded and a bubble is written. An issued store commits. The flush is remembered until termination.
- Stall without a memory op never occurs; stalls originate only here.

Test Plan:
- lb, addr 0x1003, mem word 0x80FF_1234, mem_unsigned_i=0 → sel 1000, data_or_alu_o=0xFFFF_FF80, rf_we_wb_o=1, stall exactly until the ack cycle.
- sh, addr 0x2002, store_data_i 0x0000_ABCD → dwbm_sel_o=1100, dwbm_dat_o=0xABCD_ABCD, dwbm_we_o=1, rf_we_wb_o=0.
- lw, addr 0x3001 → no cyc, is_trap_wb_o=1, trap_code_wb_o=4, csr_data_wb_o=0x3001, zero stall cycles.
- sw with ack delayed 3 cycles, then err → mem_stall_o high for 4 cycles, trap_code_wb_o=7, cyc low after the err edge.
- lhu, addr 0x10, err and ack together → trap code 5 (err wins).
- ALU op back-to-back with a load, flush_i during BUS, then rst_i during a new BUS → ALU result in 1 cycle; flushed load gives a bubble; rst_i drops cyc/stb at the next edge; all outputs 0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: Wishbone B4 classic load/store master with lane steering,
// load extension, misaligned/bus-error traps and the MEM/WB pipeline register.
module mem_stage #(
    parameter logic [3:0] TRAP_LD_MISALIGN = 4'd4,
    parameter logic [3:0] TRAP_LD_FAULT    = 4'd5,
    parameter logic [3:0] TRAP_ST_MISALIGN = 4'd6,
    parameter logic [3:0] TRAP_ST_FAULT    = 4'd7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_mem_i,
    input  logic [31:0] pc4_mem_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_mem_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic        rf_we_i,
    input  logic [1:0]  mux_sel_i,
    input  logic [1:0]  csr_op_i,
    input  logic        is_csr_i,
    input  logic        is_rs1_i,
    input  logic [31:0] csr_data_i,
    input  logic [11:0] csr_addr_i,
    input  logic        is_trap_i,
    input  logic [3:0]  trap_code_i,
    input  logic        flush_i,
    output logic [31:0] dwbm_adr_o,
    output logic [31:0] dwbm_dat_o,
    output logic [3:0]  dwbm_sel_o,
    output logic        dwbm_we_o,
    output logic        dwbm_cyc_o,
    output logic        dwbm_stb_o,
    input  logic [31:0] dwbm_dat_i,
    input  logic        dwbm_ack_i,
    input  logic        dwbm_err_i,
    output logic        mem_stall_o,
    output logic        valid_wb_o,
    output logic [31:0] pc_wb_o,
    output logic [31:0] pc4_wb_o,
    output logic [4:0]  rd_wb_o,
    output logic [31:0] data_or_alu_o,
    output logic        rf_we_wb_o,
    output logic [1:0]  mux_sel_wb_o,
    output logic [1:0]  csr_op_wb_o,
    output logic        is_csr_wb_o,
    output logic        is_rs1_wb_o,
    output logic [31:0] csr_data_wb_o,
    output logic [11:0] csr_addr_wb_o,
    output logic        is_trap_wb_o,
    output logic [3:0]  trap_code_wb_o
);

    typedef enum logic {IDLE, BUS} state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rf_we;
        logic [1:0]  mux_sel;
        logic [1:0]  csr_op;
        logic        is_csr;
        logic        is_rs1;
        logic [31:0] csr_data;
        logic [11:0] csr_addr;
        logic        is_trap;
        logic [3:0]  trap_code;
    } wb_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d, cyc_q, cyc_d;
    wb_t         wb_q, wb_d;

    logic        is_mem, misaligned, mem_req, bus_done, stall;
    logic [3:0]  lane_sel;
    logic [31:0] lane_dat, shifted, load_data;
    wb_t         pass;

    assign is_mem     = is_load_i | is_store_i;
    assign misaligned = ((mem_size_i == 2'b01) & alu_result_i[0])
                      | (mem_size_i[1] & (alu_result_i[1:0] != 2'b00));
    assign mem_req    = valid_i & is_mem & ~is_trap_i & ~misaligned & ~flush_i;
    assign bus_done   = dwbm_ack_i | dwbm_err_i;
    assign shifted    = dwbm_dat_i >> {alu_result_i[1:0], 3'b000};

    always_comb begin
        lane_sel  = 4'b1111;
        lane_dat  = store_data_i;
        load_data = dwbm_dat_i;
        case (mem_size_i)
            2'b00: begin
                lane_sel  = 4'b0001 << alu_result_i[1:0];
                lane_dat  = {4{store_data_i[7:0]}};
                load_data = {{24{~mem_unsigned_i & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                lane_sel  = 4'b0011 << alu_result_i[1:0];
                lane_dat  = {2{store_data_i[15:0]}};
                load_data = {{16{~mem_unsigned_i & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        pass = '{valid: 1'b1, pc: pc_mem_i, pc4: pc4_mem_i, rd: rd_mem_i,
                 data: alu_result_i, rf_we: rf_we_i, mux_sel: mux_sel_i,
                 csr_op: csr_op_i, is_csr: is_csr_i, is_rs1: is_rs1_i,
                 csr_data: csr_data_i, csr_addr: csr_addr_i,
                 is_trap: is_trap_i, trap_code: trap_code_i};
    end

    always_comb begin
        state_d = state_q;
        flush_d = flush_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        wb_d    = '0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                if (mem_req) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = is_store_i;
                    adr_d   = {alu_result_i[31:2], 2'b00};
                    sel_d   = lane_sel;
                    dat_d   = lane_dat;
                    stall   = 1'b1;
                end else if (valid_i & ~flush_i) begin
                    wb_d = pass;
                    if (is_trap_i) begin
                        wb_d.rf_we = 1'b0;
                    end else if (is_mem) begin
                        wb_d.is_trap   = 1'b1;
                        wb_d.trap_code = is_load_i ? TRAP_LD_MISALIGN : TRAP_ST_MISALIGN;
                        wb_d.rf_we     = 1'b0;
                        wb_d.csr_data  = alu_result_i;
                    end
                end
            end
            BUS: begin
                stall   = ~bus_done;
                flush_d = flush_q | flush_i;
                if (bus_done) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    // A flush seen at any point of the cycle discards the result.
                    if (~(flush_q | flush_i)) begin
                        wb_d = pass;
                        if (dwbm_err_i) begin
                            wb_d.is_trap   = 1'b1;
                            wb_d.trap_code = is_load_i ? TRAP_LD_FAULT : TRAP_ST_FAULT;
                            wb_d.rf_we     = 1'b0;
                            wb_d.csr_data  = alu_result_i;
                        end else if (is_load_i) begin
                            wb_d.data = load_data;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            wb_q    <= wb_d;
        end
    end

    assign mem_stall_o    = stall & ~rst_i;
    assign dwbm_adr_o     = adr_q;
    assign dwbm_dat_o     = dat_q;
    assign dwbm_sel_o     = sel_q;
    assign dwbm_we_o      = we_q;
    assign dwbm_cyc_o     = cyc_q;
    assign dwbm_stb_o     = cyc_q;
    assign valid_wb_o     = wb_q.valid;
    assign pc_wb_o        = wb_q.pc;
    assign pc4_wb_o       = wb_q.pc4;
    assign rd_wb_o        = wb_q.rd;
    assign data_or_alu_o  = wb_q.data;
    assign rf_we_wb_o     = wb_q.rf_we;
    assign mux_sel_wb_o   = wb_q.mux_sel;
    assign csr_op_wb_o    = wb_q.csr_op;
    assign is_csr_wb_o    = wb_q.is_csr;
    assign is_rs1_wb_o    = wb_q.is_rs1;
    assign csr_data_wb_o  = wb_q.csr_data;
    assign csr_addr_wb_o  = wb_q.csr_addr;
    assign is_trap_wb_o   = wb_q.is_trap;
    assign trap_code_wb_o = wb_q.trap_code;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random EX/MEM traffic against a byte-level
// memory model; a monitor compares every valid WB record against the queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, is_load_i, is_store_i, mem_unsigned_i, rf_we_i;
    logic        is_csr_i, is_rs1_i, is_trap_i, flush_i;
    logic [31:0] pc_mem_i, pc4_mem_i, alu_result_i, store_data_i, csr_data_i;
    logic [4:0]  rd_mem_i;
    logic [1:0]  mem_size_i, mux_sel_i, csr_op_i;
    logic [11:0] csr_addr_i;
    logic [3:0]  trap_code_i;
    logic [31:0] dwbm_adr_o, dwbm_dat_o, dwbm_dat_i;
    logic [3:0]  dwbm_sel_o;
    logic        dwbm_we_o, dwbm_cyc_o, dwbm_stb_o, dwbm_ack_i, dwbm_err_i, mem_stall_o;
    logic        valid_wb_o, rf_we_wb_o, is_csr_wb_o, is_rs1_wb_o, is_trap_wb_o;
    logic [31:0] pc_wb_o, pc4_wb_o, data_or_alu_o, csr_data_wb_o;
    logic [4:0]  rd_wb_o;
    logic [1:0]  mux_sel_wb_o, csr_op_wb_o;
    logic [11:0] csr_addr_wb_o;
    logic [3:0]  trap_code_wb_o;

    mem_stage dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .pc_mem_i(pc_mem_i),
        .pc4_mem_i(pc4_mem_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .rd_mem_i(rd_mem_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .rf_we_i(rf_we_i),
        .mux_sel_i(mux_sel_i), .csr_op_i(csr_op_i), .is_csr_i(is_csr_i), .is_rs1_i(is_rs1_i),
        .csr_data_i(csr_data_i), .csr_addr_i(csr_addr_i), .is_trap_i(is_trap_i),
        .trap_code_i(trap_code_i), .flush_i(flush_i),
        .dwbm_adr_o(dwbm_adr_o), .dwbm_dat_o(dwbm_dat_o), .dwbm_sel_o(dwbm_sel_o),
        .dwbm_we_o(dwbm_we_o), .dwbm_cyc_o(dwbm_cyc_o), .dwbm_stb_o(dwbm_stb_o),
        .dwbm_dat_i(dwbm_dat_i), .dwbm_ack_i(dwbm_ack_i), .dwbm_err_i(dwbm_err_i),
        .mem_stall_o(mem_stall_o), .valid_wb_o(valid_wb_o), .pc_wb_o(pc_wb_o),
        .pc4_wb_o(pc4_wb_o), .rd_wb_o(rd_wb_o), .data_or_alu_o(data_or_alu_o),
        .rf_we_wb_o(rf_we_wb_o), .mux_sel_wb_o(mux_sel_wb_o), .csr_op_wb_o(csr_op_wb_o),
        .is_csr_wb_o(is_csr_wb_o), .is_rs1_wb_o(is_rs1_wb_o), .csr_data_wb_o(csr_data_wb_o),
        .csr_addr_wb_o(csr_addr_wb_o), .is_trap_wb_o(is_trap_wb_o),
        .trap_code_wb_o(trap_code_wb_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rf_we;
        logic [1:0]  mux_sel;
        logic [1:0]  csr_op;
        logic        is_csr;
        logic        is_rs1;
        logic [31:0] csr_data;
        logic [11:0] csr_addr;
        logic        is_trap;
        logic [3:0]  code;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [int unsigned];
    int          checks = 0;
    int          errors = 0;
    bit          started = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input int unsigned w);
        if (!mem.exists(w)) mem[w] = $urandom;
        return mem[w];
    endfunction

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        logic [31:0] w;
        w = rd_word(a >> 2);
        return 8'((w >> (8 * (a % 4))) & 32'hFF);
    endfunction

    task automatic wr_byte(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w, m;
        w = rd_word(a >> 2);
        m = 32'hFF << (8 * (a % 4));
        mem[a >> 2] = (w & ~m) | ((32'(b) << (8 * (a % 4))) & m);
    endtask

    // Monitor: every valid WB record must match the head of the queue.
    initial begin
        exp_t act, e;
        forever begin
            @(negedge clk);
            if (started && !rst_i) begin
                if (valid_wb_o === 1'b1) begin
                    act = {pc_wb_o, pc4_wb_o, rd_wb_o, data_or_alu_o, rf_we_wb_o,
                           mux_sel_wb_o, csr_op_wb_o, is_csr_wb_o, is_rs1_wb_o,
                           csr_data_wb_o, csr_addr_wb_o, is_trap_wb_o, trap_code_wb_o};
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wb_unexpected: got valid_wb_o=1 expected no output");
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_record", act, e);
                    end
                end else begin
                    check("bubble_flags", {rf_we_wb_o, is_trap_wb_o, is_csr_wb_o}, 0);
                end
            end
        end
    end

    // Issue one EX/MEM slot (called just after a rising edge) and serve its bus cycle.
    // fl: -1 none, 0 flush while idle, k>0 flush in the k-th bus cycle.
    task automatic run_op(input bit v, ld, st, trp, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, sdata, input int dly,
                          input bit err, both, input int fl);
        exp_t        e;
        int          n, stalls;
        bit          misal, req;
        logic [31:0] val, edat;
        logic [3:0]  esel;
        valid_i = v; is_load_i = ld; is_store_i = st; is_trap_i = trp;
        trap_code_i = trp ? 4'($urandom) : 4'd0;
        mem_size_i = sz; mem_unsigned_i = uns; alu_result_i = addr; store_data_i = sdata;
        pc_mem_i = $urandom & ~32'd3; pc4_mem_i = pc_mem_i + 32'd4; rd_mem_i = 5'($urandom);
        rf_we_i = st ? 1'b0 : (ld ? 1'b1 : 1'($urandom));
        mux_sel_i = 2'($urandom); csr_op_i = 2'($urandom); is_csr_i = 1'($urandom);
        is_rs1_i = 1'($urandom); csr_data_i = $urandom; csr_addr_i = 12'($urandom);
        flush_i = (fl == 0);
        n = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
        misal = (addr % n) != 0;
        req = v && (ld || st) && !trp && !misal && (fl != 0);
        e = '{pc: pc_mem_i, pc4: pc4_mem_i, rd: rd_mem_i, data: addr, rf_we: rf_we_i,
              mux_sel: mux_sel_i, csr_op: csr_op_i, is_csr: is_csr_i, is_rs1: is_rs1_i,
              csr_data: csr_data_i, csr_addr: csr_addr_i, is_trap: trp, code: trap_code_i};
        if (trp) begin
            e.rf_we = 1'b0;
        end else if ((ld || st) && (misal || err)) begin
            e.is_trap = 1'b1;
            e.code = misal ? (ld ? 4'd4 : 4'd6) : (ld ? 4'd5 : 4'd7);
            e.rf_we = 1'b0;
            e.csr_data = addr;
        end else if (ld) begin
            val = 0;
            for (int i = 0; i < n; i++) val |= 32'(rd_byte(addr + i)) << (8 * i);
            if (!uns && n < 4 && val[8 * n - 1]) val |= 32'hFFFF_FFFF << (8 * n);
            e.data = val;
        end
        if (v && (fl < 0 || (fl > 0 && !req))) exp_q.push_back(e);
        esel = 0;
        for (int i = 0; i < n; i++) esel[(addr % 4) + i] = 1'b1;
        edat = (n == 1) ? {4{sdata[7:0]}} : ((n == 2) ? {2{sdata[15:0]}} : sdata);
        @(negedge clk);
        check("idle_cyc", dwbm_cyc_o, 0);
        stalls = mem_stall_o;
        if (req) begin
            for (int k = 0; k <= dly; k++) begin
                @(posedge clk); #1;
                flush_i = (fl == k + 1);
                dwbm_ack_i = (k == dly) && (!err || both);
                dwbm_err_i = (k == dly) && err;
                dwbm_dat_i = (ld && k == dly) ? rd_word(addr >> 2) : $urandom;
                @(negedge clk);
                stalls += mem_stall_o;
                check("bus_fields",
                      {dwbm_cyc_o, dwbm_stb_o, dwbm_we_o, dwbm_adr_o, dwbm_sel_o,
                       st ? dwbm_dat_o : 32'd0},
                      {1'b1, 1'b1, st, addr & ~32'd3, esel, st ? edat : 32'd0});
            end
            if (st && !err)
                for (int i = 0; i < n; i++) wr_byte(addr + i, 8'(sdata >> (8 * i)));
        end
        check("stall_cycles", stalls, req ? 1 + dly : 0);
        @(posedge clk); #1;
        dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        int kind, dly, fl, r;
        bit err;
        logic [1:0]  sz;
        logic [31:0] addr;
        rst_i = 1'b1; valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; is_trap_i = 1'b0;
        mem_size_i = 2'b10; mem_unsigned_i = 1'b0; alu_result_i = 32'h40; store_data_i = 0;
        pc_mem_i = 0; pc4_mem_i = 0; rd_mem_i = 0; rf_we_i = 1'b1; mux_sel_i = 0; csr_op_i = 0;
        is_csr_i = 1'b0; is_rs1_i = 1'b0; csr_data_i = 0; csr_addr_i = 0; trap_code_i = 0;
        flush_i = 1'b0; dwbm_dat_i = 0; dwbm_ack_i = 1'b0; dwbm_err_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {dwbm_adr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
               mem_stall_o, valid_wb_o, pc_wb_o, pc4_wb_o, rd_wb_o, data_or_alu_o,
               rf_we_wb_o, mux_sel_wb_o, csr_op_wb_o, is_csr_wb_o, is_rs1_wb_o,
               csr_data_wb_o, csr_addr_wb_o, is_trap_wb_o, trap_code_wb_o}, 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        started = 1'b1;

        mem[32'h1000 >> 2] = 32'h80FF_1234;
        run_op(1, 1, 0, 0, 2'b00, 0, 32'h1003, 0, 1, 0, 0, -1);
        run_op(1, 0, 1, 0, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 0, 0, 0, -1);
        run_op(1, 1, 0, 0, 2'b10, 0, 32'h3001, 0, 0, 0, 0, -1);
        run_op(1, 0, 1, 0, 2'b10, 0, 32'h4000, $urandom, 3, 1, 0, -1);
        run_op(1, 1, 0, 0, 2'b01, 1, 32'h10, 0, 0, 1, 1, -1);

        for (int it = 0; it < 300; it++) begin
            kind = $urandom % 8;
            sz = 2'($urandom);
            addr = 32'h100 + 32'(($urandom % 8) * 4) + 32'($urandom % 4);
            if ($urandom % 3 != 0) addr = (sz == 2'b00) ? addr : ((sz == 2'b01) ? addr & ~32'd1 : addr & ~32'd3);
            dly = $urandom % 4;
            err = ($urandom % 8) == 0;
            r = $urandom % 16;
            fl = (r == 0) ? 0 : ((r == 1 && kind >= 2 && kind <= 6) ? $urandom_range(1, dly + 1) : -1);
            case (kind)
                0, 1:    run_op(1, 0, 0, 0, sz, 1'($urandom), $urandom, $urandom, 0, 0, 0, fl);
                2, 3, 4: run_op(1, 1, 0, 0, sz, 1'($urandom), addr, $urandom, dly, err, 1'($urandom), fl);
                5, 6:    run_op(1, 0, 1, 0, sz, 0, addr, $urandom, dly, err, 1'($urandom), fl);
                default: run_op(1'($urandom), 1'($urandom), 0, 1, sz, 0, addr, $urandom, dly, 0, 0, -1);
            endcase
        end

        run_op(1, 0, 0, 0, 2'b10, 0, 32'h1234_5678, 0, 0, 0, 0, -1);
        run_op(1, 1, 0, 0, 2'b10, 0, 32'h200, 0, 2, 0, 0, 2);
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; is_trap_i = 1'b0;
        mem_size_i = 2'b10; alu_result_i = 32'h500; flush_i = 1'b0;
        @(negedge clk);
        check("rst_seq_stall", mem_stall_o, 1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_seq_cyc_before", dwbm_cyc_o, 1);
        @(posedge clk); #1;
        rst_i = 1'b0; valid_i = 1'b0; dwbm_ack_i = 1'b1; dwbm_dat_i = $urandom;
        @(negedge clk);
        check("rst_seq_outputs",
              {dwbm_adr_o, dwbm_dat_o, dwbm_sel_o, dwbm_we_o, dwbm_cyc_o, dwbm_stb_o,
               mem_stall_o, valid_wb_o, pc_wb_o, pc4_wb_o, rd_wb_o, data_or_alu_o,
               rf_we_wb_o, mux_sel_wb_o, csr_op_wb_o, is_csr_wb_o, is_rs1_wb_o,
               csr_data_wb_o, csr_addr_wb_o, is_trap_wb_o, trap_code_wb_o}, 0);
        @(posedge clk); #1;
        dwbm_ack_i = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {dwbm_cyc_o, valid_wb_o}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
